// File: rtl/ula_serial_fatias.sv
// Slice-serial ALU: processes FATIA bits per clock, LSB slice first, with a
// registered inter-slice carry, start/busy/done handshake and registered flags.
module ula_serial_fatias #(
  parameter int unsigned LARGURA = 12,
  parameter int unsigned FATIA   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inicio,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  input  logic               carry_in,
  input  logic [2:0]         seletor,
  output logic [LARGURA-1:0] resultado,
  output logic               carry_out,
  output logic               zero,
  output logic               negativo,
  output logic               overflow,
  output logic               ocupado,
  output logic               pronto
);

  localparam int unsigned NumFatias = LARGURA / FATIA;
  localparam int unsigned CntW      = (NumFatias > 1) ? $clog2(NumFatias) : 1;

  typedef enum logic {StOcioso, StCalcula} estado_e;

  estado_e            estado_q, estado_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [LARGURA-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic [2:0]         sel_q, sel_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d, zero_q, zero_d, neg_q, neg_d;
  logic               ovf_q, ovf_d, pronto_q, pronto_d;

  // Slice datapath
  logic [31:0]       base;
  logic [FATIA-1:0]  a_s, b_s, b_eff, soma, fatia;
  logic              c, c_msb_in, arit;

  always_comb begin
    base     = 32'(cnt_q) * FATIA;
    a_s      = a_q[base +: FATIA];
    b_s      = b_q[base +: FATIA];
    arit     = sel_q[2] & ~sel_q[1];
    b_eff    = (sel_q == 3'b101) ? ~b_s : b_s;
    c        = carry_q;
    c_msb_in = 1'b0;
    soma     = '0;
    for (int i = 0; i < int'(FATIA); i++) begin
      if (i == int'(FATIA) - 1) c_msb_in = c;
      soma[i] = a_s[i] ^ b_eff[i] ^ c;
      c       = (a_s[i] & b_eff[i]) | (c & (a_s[i] ^ b_eff[i]));
    end
    case (sel_q)
      3'b000:  fatia = a_s & b_s;
      3'b001:  fatia = a_s | b_s;
      3'b010:  fatia = a_s ^ b_s;
      3'b011:  fatia = ~a_s;
      3'b110:  fatia = a_s;
      3'b111:  fatia = b_s;
      default: fatia = soma;
    endcase
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    carry_d  = carry_q;
    acc_d    = acc_q;
    res_d    = res_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    pronto_d = 1'b0;
    unique case (estado_q)
      StOcioso: begin
        if (inicio) begin
          a_d      = A;
          b_d      = B;
          sel_d    = seletor;
          carry_d  = carry_in;
          cnt_d    = '0;
          estado_d = StCalcula;
        end
      end
      StCalcula: begin
        acc_d[base +: FATIA] = fatia;
        // Logic ops leave the carry register untouched; it is unused for them.
        if (arit) carry_d = c;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NumFatias - 1)) begin
          res_d    = acc_d;
          cout_d   = arit & c;
          ovf_d    = arit & (c_msb_in ^ c);
          zero_d   = (acc_d == '0);
          neg_d    = acc_d[LARGURA-1];
          pronto_d = 1'b1;
          cnt_d    = '0;
          estado_d = StOcioso;
        end
      end
      default: estado_d = StOcioso;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= StOcioso;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      carry_q  <= 1'b0;
      acc_q    <= '0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      carry_q  <= carry_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      pronto_q <= pronto_d;
    end
  end

  assign resultado = res_q;
  assign carry_out = cout_q;
  assign zero      = zero_q;
  assign negativo  = neg_q;
  assign overflow  = ovf_q;
  assign ocupado   = (estado_q == StCalcula);
  assign pronto    = pronto_q;

endmodule

// File: doc/ula_serial_fatias.md
# ula_serial_fatias

Parametrised, multi-cycle successor to the 12-bit carry-look-ahead ALU. It processes the operands one FATIA-bit slice per clock, LSB slice first, and holds the inter-slice carry in a register. This trades latency for area, so one slice datapath serves any LARGURA. A start/busy/done handshake is added, along with registered status flags (zero, negative, signed overflow) that the combinational ALU does not provide.

## Interface
- LARGURA, 12: operand/result width. Must be an integer multiple of FATIA and ≥ FATIA.
- FATIA, 4: slice width processed per cycle. NUM_FATIAS = LARGURA/FATIA.

- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- inicio  input  1  start request. Sampled only when ocupado=0.
- A  input  LARGURA  operand A. Captured on accepted inicio.
- B  input  LARGURA  operand B. Captured on accepted inicio.
- carry_in  input  1  carry-in to slice 0. Captured on accepted inicio.
- seletor  input  3  operation select. Captured on accepted inicio.
- resultado  output  LARGURA  result of the last completed operation.
- carry_out  output  1  carry out of the MSB (arithmetic ops only, else 0).
- zero  output  1  resultado == 0.
- negativo  output  1  resultado[LARGURA-1].
- overflow  output  1  two's-complement overflow (arithmetic ops only, else 0).
- ocupado  output  1  operation in progress.
- pronto  output  1  one-cycle completion pulse.

## Operation
- Operations (seletor):
  - 000: A AND B
  - 001: A OR B
  - 010: A XOR B
  - 011: NOT A
  - 100: A + B + carry_in
  - 101: A + ~B + carry_in. This is a true subtract when carry_in=1; carry_out=1 means no borrow.
  - 110: pass A
  - 111: pass B
- State machine, 2 states:
  - OCIOSO: ocupado=0. On inicio=1, capture A, B, carry_in and seletor into internal registers, load carry register with carry_in, set the slice counter to 0, and go to CALCULA.
  - CALCULA: ocupado=1. Each cycle, compute slice k (bits k·FATIA+FATIA-1 .. k·FATIA) from the captured operands and the carry register. Write the slice into an internal accumulator, update the carry register with the slice carry-out, and increment the counter.
  - When k = NUM_FATIAS-1, on the same edge: load resultado from the accumulator plus the final slice, update carry_out and all flags, pulse pronto, and return to OCIOSO.
- Logic ops ignore and do not propagate carry. Their carry_out=0 and overflow=0.
- overflow = (carry into bit LARGURA-1) XOR (carry out of bit LARGURA-1). It is computed inside the final slice.
- resultado, carry_out and the flags change only on the completion edge. They hold their values until the next completion.
- inicio while ocupado=1 is ignored, with no queueing.
- inicio high in the cycle where pronto=1 is accepted, since ocupado is already 0. Operations can run back-to-back with no idle cycle.
- Input changes after capture do not affect the operation in progress.

## Timing
- Reset (async assert, synchronous-style release on the next clk edge): state OCIOSO, counter 0, carry register 0.
- All outputs are 0 on reset: resultado, carry_out, zero, negativo, overflow, ocupado, pronto.
- zero resets to 0, not 1. Flags are valid only after the first completion.
- Edge t0 samples inicio=1 with ocupado=0. ocupado=1 from t0.
- Slices 0..NUM_FATIAS-1 are computed on edges t0+1 .. t0+NUM_FATIAS.
- pronto=1 and ocupado=0 in the cycle after edge t0+NUM_FATIAS, i.e. latency is NUM_FATIAS cycles: 3 at the defaults.
- pronto is high for exactly one cycle per accepted start.
- Throughput: one operation per NUM_FATIAS cycles.
- Reset mid-operation aborts immediately. No pronto is issued, and outputs return to 0.
- NUM_FATIAS=1 is legal: single-cycle CALCULA, latency 1.

## Test plan
- Default params, seletor=100, A=0xFFF, B=0x001, carry_in=0 -> pronto 3 cycles after accept; resultado=0x000, carry_out=1, zero=1, negativo=0, overflow=0.
- seletor=100, A=0x7FF, B=0x001, carry_in=0 -> resultado=0x800, carry_out=0, overflow=1, negativo=1. Then seletor=101, A=0x005, B=0x007, carry_in=1 -> resultado=0xFFE, carry_out=0, negativo=1, overflow=0.
- seletor=010, A=0xA5A, B=0xFFF -> resultado=0x5A5, carry_out=0, overflow=0. Then seletor=011, A=0xFFF -> resultado=0x000, zero=1.
- Accept an op, then pulse inicio again at t0+1 with different operands -> second request ignored, single pronto, first result. inicio held during the pronto cycle -> second op accepted, with its pronto 3 cycles later.
- Assert rst at t0+2 mid-operation -> outputs 0 immediately, no pronto. After release a new op completes normally.
- LARGURA=16, FATIA=4: seletor=100, A=0xFFFF, B=0x0001, carry_in=0 -> latency 4, resultado=0x0000, carry_out=1, zero=1. Plus random arith/logic ops compared against a reference model.
